// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues request-to-send,
//   then shifts one byte (d0..d7, odd parity, stop) out on device clock edges and checks the ACK.
// Latency: clock line low for INHIBIT_CYCLES+1 cycles after accept; done 1 cycle after bus idle.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is ignored.
//
// Ports:
//   clk, rst                   system clock, asynchronous active-high reset
//   ps2_clk_in, ps2_data_in    raw open-drain line levels (asynchronous to clk)
//   ps2_clk_low, ps2_data_low  1 = pull the line low, 0 = release (high-Z at top level)
//   tx_data, tx_valid, tx_ready  command byte handshake
//   busy                       high in every state except IDLE
//   done                       one-cycle end-of-transfer pulse
//   ack_err, timeout           transfer status, valid with done, held until next accept
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 10_000,
    parameter int START_TIMEOUT_CYCLES = 1_500_000,
    parameter int XFER_TIMEOUT_CYCLES  = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int          IW         = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] START_LAST = 21'(START_TIMEOUT_CYCLES - 1);
    localparam logic [20:0] XFER_LAST  = 21'(XFER_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_WAIT_FIRST,
        S_SHIFT,
        S_ACK_WAIT,
        S_WAIT_IDLE,
        S_ABORT
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          sclk_d;
    logic          sclk;
    logic          sdat;
    logic          fell;
    logic [9:0]    frame;      // {stop, parity, d7..d0}, sent LSB first
    logic [3:0]    bit_idx;
    logic [IW-1:0] inh_cnt;
    logic [20:0]   start_cnt;
    logic [20:0]   xfer_cnt;

    // Two-flop synchronizers; idle bus level is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            sclk_d   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            sclk_d   <= clk_sync[1];
        end
    end

    assign sclk = clk_sync[1];
    assign sdat = dat_sync[1];
    assign fell = sclk_d & ~sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            ack_err      <= 1'b0;
            timeout      <= 1'b0;
            frame        <= '0;
            bit_idx      <= '0;
            inh_cnt      <= '0;
            start_cnt    <= '0;
            xfer_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, ~^tx_data, tx_data};
                        ack_err     <= 1'b0;
                        timeout     <= 1'b0;
                        bit_idx     <= '0;
                        inh_cnt     <= '0;
                        start_cnt   <= '0;
                        xfer_cnt    <= '0;
                        ps2_clk_low <= 1'b1;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_INHIBIT;
                    end
                end

                // A device pulling data low here is a collided frame; nothing to do about it.
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_low <= 1'b1;
                        state        <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                S_RTS: begin
                    ps2_clk_low <= 1'b0;
                    state       <= S_WAIT_FIRST;
                end

                // The start bit has already been presented by RTS, so the first device
                // falling edge puts d0 on the line straight away; SHIFT carries on from d1.
                S_WAIT_FIRST: begin
                    if (start_cnt == START_LAST) begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        state        <= S_ABORT;
                    end else begin
                        if (start_cnt != '1) start_cnt <= start_cnt + 21'd1;
                        if (fell) begin
                            ps2_data_low <= ~frame[0];
                            bit_idx      <= 4'd1;
                            state        <= S_SHIFT;
                        end
                    end
                end

                // Expiry is checked before the line edge so a coincident timeout wins.
                S_SHIFT, S_ACK_WAIT, S_WAIT_IDLE: begin
                    if (xfer_cnt == XFER_LAST) begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        state        <= S_ABORT;
                    end else begin
                        if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 21'd1;
                        if (state == S_SHIFT) begin
                            if (fell) begin
                                // Stop bit is a 1, so driving it releases the data line.
                                ps2_data_low <= ~frame[bit_idx];
                                if (bit_idx == 4'd9) state <= S_ACK_WAIT;
                                else                 bit_idx <= bit_idx + 4'd1;
                            end
                        end else if (state == S_ACK_WAIT) begin
                            if (fell) begin
                                ack_err <= sdat;
                                state   <= S_WAIT_IDLE;
                            end
                        end else begin
                            if (sclk && sdat) begin
                                done     <= 1'b1;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                                state    <= S_IDLE;
                            end
                        end
                    end
                end

                S_ABORT: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    done         <= 1'b1;
                    timeout      <= 1'b1;
                    ack_err      <= 1'b0;
                    tx_ready     <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on a wired-AND bus.
// Device clock half period is H cycles; the device samples data just before each rising edge.
module tb_ps2_host_tx;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_ctr = 0;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_low;
    assign ps2_data_in = dev_data & ~ps2_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (20),
        .START_TIMEOUT_CYCLES(50),
        .XFER_TIMEOUT_CYCLES (300)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_low (ps2_clk_low),
        .ps2_data_low(ps2_data_low),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the first sample after the accept edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // bits[0] = start, bits[8:1] = d7..d0, bits[9] = parity, bits[10] = stop.
    task automatic dev_run(input int n_clk, input bit do_ack,
                           output logic [10:0] bits, output int fall1_at);
        int w;
        bits     = '0;
        fall1_at = 0;
        w        = 0;
        while (!(ps2_clk_low == 1'b0 && ps2_data_low == 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("rts_seen", (w < 200), 1);
        repeat (H) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= n_clk; i++) begin
            dev_clk = 1'b0;
            if (i == 1) fall1_at = cyc_ctr;
            repeat (H) @(negedge clk);
            if (i <= 10) bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 11) begin
                dev_data = 1'b1;
            end else begin
                repeat (2) @(negedge clk);
                if (i == 10 && do_ack) dev_data = 1'b0;
                repeat (H - 2) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input string tag, output int at);
        int w;
        w = 0;
        while (done !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, done, 1);
        at = cyc_ctr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        int          f1;
        int          at;
        int          clk_cnt;
        int          last_cl;
        int          first_dl;
        logic        dl[1:80];
        logic        cl[1:80];
        logic        dn[1:80];
        logic        to[1:80];
        logic        ae[1:80];
        logic        rd[1:80];

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check_eq("rst_clk_low", ps2_clk_low, 0);
        check_eq("rst_data_low", ps2_data_low, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ack_err", ack_err, 0);
        check_eq("rst_timeout", timeout, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---- 0xF4 with ACK: inhibit/RTS timing and frame ----
        send(8'hF4);
        check_eq("f4_busy", busy, 1);
        check_eq("f4_ready_low", tx_ready, 0);
        clk_cnt  = 0;
        last_cl  = 0;
        first_dl = 0;
        for (int j = 1; j <= 25; j++) begin
            if (ps2_clk_low) begin
                clk_cnt++;
                last_cl = j;
            end
            if (ps2_data_low && first_dl == 0) first_dl = j;
            @(negedge clk);
        end
        check_eq("f4_clk_low_cycles", clk_cnt, 21);
        check_eq("f4_clk_low_last", last_cl, 21);
        check_eq("f4_data_low_first", first_dl, 21);
        dev_run(11, 1'b1, bits, f1);
        check_eq("f4_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_done("f4_done", at);
        check_eq("f4_ack_err", ack_err, 0);
        check_eq("f4_timeout", timeout, 0);
        check_eq("f4_ready_with_done", tx_ready, 1);
        @(negedge clk);
        check_eq("f4_done_one_cycle", done, 0);
        check_eq("f4_ack_err_held", ack_err, 0);
        repeat (5) @(negedge clk);

        // ---- 0xED, device does not ACK ----
        send(8'hED);
        dev_run(11, 1'b0, bits, f1);
        check_eq("ed_parity", bits[9], 1);
        check_eq("ed_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        wait_done("ed_done", at);
        check_eq("ed_ack_err", ack_err, 1);
        check_eq("ed_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        check_eq("ed_ack_err_held", ack_err, 1);

        // ---- 0xFF, device never clocks: start timeout ----
        send(8'hFF);
        check_eq("ff_ack_err_cleared", ack_err, 0);
        for (int j = 1; j <= 75; j++) begin
            dl[j] = ps2_data_low;
            cl[j] = ps2_clk_low;
            dn[j] = done;
            to[j] = timeout;
            ae[j] = ack_err;
            rd[j] = tx_ready;
            @(negedge clk);
        end
        check_eq("ff_data_low_before", dl[71], 1);
        check_eq("ff_clk_released_wait", cl[71], 0);
        check_eq("ff_data_released", dl[72], 0);
        check_eq("ff_clk_released", cl[72], 0);
        check_eq("ff_no_early_done", dn[72], 0);
        check_eq("ff_done", dn[73], 1);
        check_eq("ff_timeout", to[73], 1);
        check_eq("ff_ack_err", ae[73], 0);
        check_eq("ff_ready_with_done", rd[73], 1);
        check_eq("ff_done_one_cycle", dn[74], 0);
        check_eq("ff_timeout_held", to[75], 1);
        repeat (3) @(negedge clk);

        // ---- device stops after 4 bits: transfer timeout ----
        send(8'hF0);
        check_eq("xto_timeout_cleared", timeout, 0);
        dev_run(4, 1'b0, bits, f1);
        check_eq("xto_bits", bits[4:0], {4'b0000, 1'b0});
        wait_done("xto_done", at);
        check_eq("xto_done_latency", at - f1, 304);
        check_eq("xto_timeout", timeout, 1);
        check_eq("xto_ack_err", ack_err, 0);
        check_eq("xto_lines", {ps2_clk_low, ps2_data_low}, 2'b00);
        @(negedge clk);
        check_eq("xto_ready_next", tx_ready, 1);
        check_eq("xto_busy_next", busy, 0);
        repeat (3) @(negedge clk);

        // ---- second request during SHIFT is ignored ----
        send(8'hA5);
        fork
            dev_run(11, 1'b1, bits, f1);
            begin
                repeat (60) @(negedge clk);
                check_eq("dup_ready_low", tx_ready, 0);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                repeat (5) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check_eq("dup_frame", bits, {1'b1, 1'b1, 8'hA5, 1'b0});
        wait_done("dup_done", at);
        check_eq("dup_ack_err", ack_err, 0);
        clk_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (ps2_clk_low) clk_cnt++;
        end
        check_eq("dup_no_second_xfer", clk_cnt, 0);
        check_eq("dup_idle", busy, 0);

        // ---- reset during SHIFT, then a clean 0x00 ----
        send(8'h12);
        dev_run(3, 1'b0, bits, f1);
        check_eq("rst_mid_data_driven", ps2_data_low, 1);
        check_eq("rst_mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_lines", {ps2_clk_low, ps2_data_low}, 2'b00);
        check_eq("rst_mid_ready", tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h00);
        dev_run(11, 1'b1, bits, f1);
        check_eq("z_frame", bits, {1'b1, 1'b1, 8'h00, 1'b0});
        wait_done("z_done", at);
        check_eq("z_ack_err", ack_err, 0);
        check_eq("z_timeout", timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
